// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one byte-wide UART serializer
// among N_REQ requesters. Latches the winner's byte, raises tx_start until
// the resynchronized busy flag rises, then waits for busy to fall.
// Optional build macro UART_ARB_TIMEOUT_EN adds a per-transaction watchdog
// that aborts a stuck transaction after TIMEOUT_CYCLES clk cycles.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   done,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic [IDX_W-1:0]   grant_id,
    output logic               active,
    output logic               timeout_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_SEND   = 2'd2;

    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    // Reject configurations the index arithmetic cannot represent.
    generate
        if (N_REQ < 2 || N_REQ > 8 || IDX_W != $clog2(N_REQ) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("uart_tx_arbiter: invalid N_REQ/IDX_W/TIMEOUT_CYCLES combination");
        end
    endgenerate

    logic [1:0]       state;
    logic [IDX_W-1:0] last;
    logic             busy_meta;
    logic             busy_s;
    logic [1:0]       sync_fill;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [7:0]       win_byte;
    logic [IDX_W-1:0] cand;
    int               scan_idx;
    logic             grant_go;

    // Two-flop resynchronizer for the serializer busy flag. The flops clear
    // on reset, so busy_s reads 0 for two cycles even while a frame is still
    // going out; sync_fill marks when the synchronizer holds real samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_meta <= 1'b0;
            busy_s    <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            busy_meta <= tx_busy;
            busy_s    <= busy_meta;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // Round-robin search starting one past the last served requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_byte  = 8'h00;
        scan_idx  = 0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = (int'(last) + k) % N_REQ;
            cand     = IDX_W'(scan_idx);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
                win_byte  = req_data[{cand, 3'b000} +: 8];
            end
        end
    end

    // Grants wait for a primed synchronizer and an idle serializer so a frame
    // left running across a reset is never overlapped.
    assign grant_go = (state == S_IDLE) && win_found && !busy_s && sync_fill[1];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    // Watchdog counter: cleared on the grant edge, counts LAUNCH and SEND cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (grant_go) begin
            tmo_cnt <= '0;
        end else if (state != S_IDLE) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Fires on the edge where the count reaches TIMEOUT_CYCLES.
    assign tmo_hit = (state != S_IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_err = 1'b0;
`endif

    // Transaction sequencer: IDLE -> LAUNCH (tx_start high) -> SEND -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            last     <= LAST_RST;
            grant_id <= '0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            active   <= 1'b0;
            ack      <= '0;
            done     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
        end else begin
            ack  <= '0;
            done <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (grant_go) begin
                        tx_data  <= win_byte;
                        grant_id <= win_idx;
                        ack      <= ONE_HOT0 << win_idx;
                        active   <= 1'b1;
                        tx_start <= 1'b1;
                        state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (busy_s) begin
                        tx_start <= 1'b0;
                        state    <= S_SEND;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        tx_start    <= 1'b0;
                        active      <= 1'b0;
                        timeout_err <= 1'b1;
                        last        <= grant_id;
                        state       <= S_IDLE;
                    end
`endif
                end
                S_SEND: begin
                    if (!busy_s) begin
                        done   <= ONE_HOT0 << grant_id;
                        active <= 1'b0;
                        last   <= grant_id;
                        state  <= S_IDLE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        tx_start    <= 1'b0;
                        active      <= 1'b0;
                        timeout_err <= 1'b1;
                        last        <= grant_id;
                        state       <= S_IDLE;
                    end
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (N_REQ=4, TIMEOUT_CYCLES=100). Expectations
// follow UART_ARB_TIMEOUT_EN when the bench is built with that macro.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;

    uart_tx_arbiter #(.N_REQ(4), .IDX_W(2), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .done(done), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_id(grant_id), .active(active), .timeout_err(timeout_err)
    );

    always #10 clk = ~clk;

    typedef struct { int id; logic [7:0] byt; } exp_t;
    typedef struct { logic [3:0] req; int gid; } vec_t;

    exp_t exp_q[$];
    int   pend_done[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_ack = 0;
    int   n_done = 0;

    // Serializer model: busy rises rise_dly cycles after seeing tx_start and
    // stays high busy_len cycles. Manual busy drive replaces it when disabled.
    logic model_en;
    logic model_busy = 1'b0;
    logic man_busy;
    int   rise_dly;
    int   busy_len;
    assign tx_busy = model_en ? model_busy : man_busy;

    initial begin
        forever begin
            @(negedge clk);
            if (model_en && !rst && tx_start && !model_busy) begin
                repeat (rise_dly) @(negedge clk);
                model_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every ack pops an expected grant, every done pops
    // the oldest outstanding grant.
    always @(negedge clk) begin
        if (!rst) begin
            if (ack !== 4'b0000) begin
                n_ack++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got %b expected none", ack);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_onehot", ack, 32'd1 << mon_e.id);
                    chk("grant_id", grant_id, mon_e.id);
                    chk("tx_data", tx_data, mon_e.byt);
                    pend_done.push_back(mon_e.id);
                end
            end
            if (done !== 4'b0000) begin
                n_done++;
                if (pend_done.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got %b expected none", done);
                end else begin
                    chk("done_onehot", done, 32'd1 << pend_done.pop_front());
                end
            end
            if (ack !== 4'b0000 && done !== 4'b0000) begin
                n_chk++;
                n_fail++;
                $display("FAIL ack_done_overlap: got ack=%b done=%b expected no overlap", ack, done);
            end
`ifdef UART_ARB_TIMEOUT_EN
            if (timeout_err === 1'b1 && pend_done.size() != 0) begin
                void'(pend_done.pop_front());
            end
`endif
        end
    end

    task automatic wait_ack(input int maxc, input string nm);
        int c = 0;
        while (ack === 4'b0000 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (ack === 4'b0000) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got no ack expected one within %0d cycles", nm, maxc);
        end
    endtask

    task automatic wait_done(input int maxc, input string nm);
        int c = 0;
        while (done === 4'b0000 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (done === 4'b0000) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got no done expected one within %0d cycles", nm, maxc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        pend_done.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Hard stop if the bench itself stalls.
    initial begin
        #4000000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl[8];

    initial begin
        int ack_base;
        int done_base;
        int c;
        logic te_seen;
        logic dn_seen;
        logic low_seen;
        logic [3:0] rn;

        tbl[0] = '{4'b0001, 0};
        tbl[1] = '{4'b1111, 1};
        tbl[2] = '{4'b0101, 2};
        tbl[3] = '{4'b0101, 0};
        tbl[4] = '{4'b1000, 3};
        tbl[5] = '{4'b0110, 1};
        tbl[6] = '{4'b0011, 0};
        tbl[7] = '{4'b1100, 2};

        rst = 1'b1; req = 4'b0000; req_data = 32'h0; man_busy = 1'b0;
        model_en = 1'b1; rise_dly = 0; busy_len = 10;
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_done", done, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_active", active, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant_id", grant_id, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single request with a long frame
        busy_len = 5000;
        req_data = 32'h0042_0000;
        exp_q.push_back('{2, 8'h42});
        req = 4'b0100;
        @(negedge clk);
        chk("single_ack_latency", ack, 4'b0100);
        chk("single_tx_start", tx_start, 1);
        req = 4'b0000;
        wait_done(6000, "single_done");
        chk("single_done_val", done, 4'b0100);

        // All four requesting continuously
        do_reset();
        busy_len = 10; rise_dly = 1;
        req_data = 32'hC3C2_C1C0;
        for (int i = 0; i < 8; i++) exp_q.push_back('{i % 4, 8'hC0 + 8'(i % 4)});
        ack_base = n_ack; done_base = n_done;
        req = 4'b1111;
        for (int g = 0; g < 8; g++) begin
            wait_ack(200, "rr_ack");
            if (g == 7) req = 4'b0000;
            @(negedge clk);
        end
        c = 0;
        while ((pend_done.size() != 0 || active) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("rr_ack_count", n_ack - ack_base, 8);
        chk("rr_done_count", n_done - done_base, 8);
        chk("rr_queue_empty", exp_q.size(), 0);

        // Table of request patterns from a fresh pointer
        do_reset();
        for (int r = 0; r < 8; r++) begin
            rn = 4'(r);
            for (int i = 0; i < 4; i++) req_data[8*i +: 8] = {rn, 4'(i)};
            exp_q.push_back('{tbl[r].gid, {rn, 4'(tbl[r].gid)}});
            req = tbl[r].req;
            wait_ack(20, "tbl_ack");
            req = 4'b0000;
            @(negedge clk);
            wait_done(100, "tbl_done");
        end

        // Serializer with a 3-cycle busy-rise delay
        rise_dly = 3; busy_len = 20;
        req_data = 32'h7766_5544;
        exp_q.push_back('{1, 8'h55});
        req = 4'b0010;
        wait_ack(20, "dly_ack");
        req = 4'b0000;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("dly_tx_start", tx_start, (k <= 5) ? 1 : 0);
            chk("dly_active", active, 1);
        end
        wait_done(100, "dly_done");
        chk("dly_active_end", active, 0);

        // Reset in SEND while the serializer is still busy
        model_en = 1'b0; man_busy = 1'b0; rise_dly = 0;
        req_data = 32'h5D5C_5B5A;
        exp_q.push_back('{0, 8'h5A});
        req = 4'b0001;
        wait_ack(20, "mrst_ack");
        man_busy = 1'b1;
        repeat (6) @(negedge clk);
        chk("mrst_pre_active", active, 1);
        chk("mrst_pre_tx_start", tx_start, 0);
        rst = 1'b1;
        #1;
        chk("mrst_ack", ack, 0);
        chk("mrst_done", done, 0);
        chk("mrst_tx_start", tx_start, 0);
        chk("mrst_active", active, 0);
        chk("mrst_tx_data", tx_data, 0);
        chk("mrst_grant_id", grant_id, 0);
        exp_q.delete();
        pend_done.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack_base = n_ack;
        repeat (10) @(negedge clk);
        chk("mrst_hold_no_ack", n_ack - ack_base, 0);
        chk("mrst_hold_active", active, 0);
        exp_q.push_back('{0, 8'h5A});
        man_busy = 1'b0;
        @(negedge clk);
        chk("mrst_fall_p1", ack, 0);
        @(negedge clk);
        chk("mrst_fall_p2", ack, 0);
        @(negedge clk);
        chk("mrst_regrant", ack, 4'b0001);
        req = 4'b0000;
        man_busy = 1'b1;
        repeat (5) @(negedge clk);
        man_busy = 1'b0;
        wait_done(20, "mrst_done2");

        // Serializer never goes busy
        do_reset();
        man_busy = 1'b0;
        req_data = 32'h0000_E1E0;
        exp_q.push_back('{0, 8'hE0});
`ifdef UART_ARB_TIMEOUT_EN
        exp_q.push_back('{1, 8'hE1});
`endif
        req = 4'b0011;
        wait_ack(20, "tmo_ack");
        req = 4'b0010;
        te_seen = 1'b0; dn_seen = 1'b0; low_seen = 1'b0;
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            te_seen |= timeout_err;
            dn_seen |= (done !== 4'b0000);
        end
        @(negedge clk);
`ifdef UART_ARB_TIMEOUT_EN
        chk("tmo_early", te_seen, 0);
        chk("tmo_pulse", timeout_err, 1);
        chk("tmo_tx_start", tx_start, 0);
        chk("tmo_active", active, 0);
        @(negedge clk);
        chk("tmo_pulse_width", timeout_err, 0);
        chk("tmo_next_grant", ack, 4'b0010);
        req = 4'b0000;
        c = 0;
        while (timeout_err !== 1'b1 && c < 150) begin
            @(negedge clk);
            dn_seen |= (done !== 4'b0000);
            c++;
        end
        chk("tmo_second_pulse", timeout_err, 1);
        chk("tmo_no_done", dn_seen, 0);
`else
        chk("notmo_tx_start", tx_start, 1);
        chk("notmo_active", active, 1);
        chk("notmo_err", timeout_err, 0);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            te_seen |= timeout_err;
            dn_seen |= (done !== 4'b0000);
            low_seen |= !tx_start;
        end
        chk("notmo_err_never", te_seen, 0);
        chk("notmo_start_held", low_seen, 0);
        chk("notmo_no_done", dn_seen, 0);
        req = 4'b0000;
`endif

        rst = 1'b1;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one byte-wide UART transmitter among `N_REQ` requesters. It sits between the requesting logic (debounced buttons, status reporters, etc.) and the `tx_uart` serializer. It latches the winning requester's byte, drives the serializer's start/data inputs, and tracks the serializer's busy flag to frame completion. The serializer runs on the slow baud-derived clock, so the handshake is level-based and `tx_busy` is resynchronized.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `IDX_W`, 2: width of `grant_id`; must equal clog2(`N_REQ`).
- `TIMEOUT_CYCLES`, 1_000_000: `clk` cycles allowed per transaction. Only used with `UART_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1: system clock, 50 MHz. All logic is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  `N_REQ`: per-requester request level.
- `req_data`  in  8*`N_REQ`: bytes; requester i occupies [8i+7:8i].
- `ack`  out  `N_REQ`: one-cycle one-hot pulse; byte captured.
- `done`  out  `N_REQ`: one-cycle one-hot pulse; frame finished.
- `tx_start`  out  1: start level to serializer.
- `tx_data`  out  8: byte to serializer, stable while `active`.
- `tx_busy`  in  1: serializer busy, asynchronous to `clk`.
- `grant_id`  out  `IDX_W`: index of current/last winner.
- `active`  out  1: transaction in progress.
- `timeout_err`  out  1: one-cycle pulse on abort.

## Operation
- `tx_busy` passes through a 2-flop synchronizer; the resulting signal is `busy_s`.
- Reset values:
  - `ack`, `done`, `tx_start`, `active`, `timeout_err` = 0.
  - `tx_data` = 8'h00, `grant_id` = 0.
  - Internal `last` pointer = `N_REQ`-1, so requester 0 has first priority.
  - State = IDLE.
  - Synchronizer flops = 0.
- States:
  - IDLE:
    - Grants when any `req` is high and `busy_s`=0.
    - Winner: the first requester with `req` set, searching from `last`+1 upward and wrapping modulo `N_REQ`.
    - On the grant edge:
      - `tx_data` <= winner's byte.
      - `grant_id` <= winner.
      - `ack[winner]` pulses.
      - `active` <= 1.
      - `tx_start` <= 1.
      - Next state = LAUNCH.
  - LAUNCH:
    - Holds `tx_start` high until `busy_s`=1.
    - On that edge: `tx_start` <= 0, next state = SEND.
  - SEND:
    - Waits for `busy_s`=0.
    - On that edge: `done[grant_id]` pulses, `active` <= 0, `last` <= `grant_id`, next state = IDLE.
- `req` is a level, not a queue. A requester still asserting `req` after `ack` is re-arbitrated as a new request, fairly against the others.
- `req_data` is sampled only on the grant edge.
- Boundaries:
  - All requesters asserted: grants go 0,1,2,3,0,... with no starvation.
  - Single requester: it wins every round.
  - `busy_s` already high in IDLE (serializer still finishing after a mid-frame reset): no grant until `busy_s`=0.
  - `req` deasserting during LAUNCH or SEND: no effect on the transaction.
  - Reset mid-transaction: all outputs return to reset values immediately. The frame already in flight in the serializer is not affected; the IDLE `busy_s` guard prevents overlap.

## Timing
- Grant latency: `ack` and `tx_start` rise on the first edge after `req` is seen in IDLE.
- `tx_start` stays high for at least 3 `clk` cycles (2-flop sync plus state update). It falls on the edge after `busy_s` rises.
- `done` follows the synchronized `tx_busy` fall by 1 `clk`, which is 3 edges after the raw fall.
- IDLE lasts at least 1 cycle between transactions.
- `ack`, `done` and `timeout_err` are each exactly 1 cycle wide and never overlap for different requesters.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A transaction counter clears on the grant edge and increments every cycle in LAUNCH and SEND.
  - When it reaches `TIMEOUT_CYCLES`:
    - `tx_start` <= 0 and `active` <= 0.
    - `timeout_err` pulses.
    - No `done` pulse is issued.
    - `last` <= `grant_id`.
    - State returns to IDLE.
  - A normal completion on that same edge takes precedence over the timeout.
- `UART_ARB_TIMEOUT_EN` not defined:
  - No counter; LAUNCH and SEND wait indefinitely.
  - `timeout_err` is tied to 0. The port remains present.

## Test plan
- Single request: `req`=4'b0100, `req_data[23:16]`=8'h42, serializer model busy for 5000 cycles.
  - Expect `ack`=4'b0100 one cycle after the request.
  - Expect `tx_data`=8'h42 and `grant_id`=2.
  - Expect `done`=4'b0100 once busy falls.
- All four requesting continuously: 8 grants.
  - Expect grant order 0,1,2,3,0,1,2,3.
  - Expect exactly one `ack` and one `done` per transaction, with no overlap.
- Serializer with a 3-cycle busy-rise delay:
  - Expect `tx_start` high until 2 cycles after `tx_busy` rises, then low.
  - Expect `active` high throughout the transaction.
- Reset mid-SEND while the model is still busy, with `req`=4'b0001 held:
  - Expect outputs at reset values immediately.
  - Expect no `ack` until `tx_busy` falls plus 2 cycles; then `ack`=4'b0001.
- Timeout: with `UART_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, `tx_busy` stuck at 0.
  - Expect a `timeout_err` pulse exactly 100 cycles after the grant edge.
  - Expect `tx_start` low, no `done`, and the next requester granted.
- Same stimulus without the macro:
  - Expect `tx_start` high indefinitely and `timeout_err` constant 0.
